// File: rtl/sort_result_checker.sv
// ---------------------------------------------------------------------------
// sort_result_checker
//
// Purpose:
//   Watches the stimulus fed to a parallel sorter and the sorter's output.
//   The input vector is delayed by the sorter latency so that it lines up
//   with the output it produced. Each aligned pair is then checked for two
//   properties:
//     - the output is ascending (unsigned, equal neighbours allowed)
//     - the output is a permutation of the input
//   Pass/fail counters are kept, and the first failing pair is captured.
//
// Parameters:
//   data_width   bits per element
//   num_elem     elements per packed vector (element k at [k*data_width +: data_width])
//   latency      sorter pipeline depth in cycles (0..8)
//   stop_on_err  1 = halt after the first failure, 0 = keep checking
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   clear           synchronous clear of counters, captures, delay line and FSM
//   in_valid        inps carries a new vector this cycle
//   inps            packed vector presented to the sorter
//   outp            packed sorter output
//   checks_done     vectors checked (saturating)
//   err_count       failed vectors (saturating)
//   err_flag        sticky first-failure flag
//   err_kind        first failure kind: bit0 order, bit1 permutation
//   first_err_inps  input vector of the first failure
//   first_err_outp  output vector of the first failure
//   busy            high while in RUN
// ---------------------------------------------------------------------------
module sort_result_checker #(
    parameter int data_width  = 3,
    parameter int num_elem    = 2,
    parameter int latency     = 0,
    parameter int stop_on_err = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic [num_elem*data_width-1:0] inps,
    input  logic [num_elem*data_width-1:0] outp,
    output logic [15:0]                    checks_done,
    output logic [15:0]                    err_count,
    output logic                           err_flag,
    output logic [1:0]                     err_kind,
    output logic [num_elem*data_width-1:0] first_err_inps,
    output logic [num_elem*data_width-1:0] first_err_outp,
    output logic                           busy
);

    localparam int VW = num_elem * data_width;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state, state_nx;

    // Returns 1 when some element is smaller than its lower-index neighbour.
    function automatic logic order_bad(input logic [VW-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < num_elem - 1; k++) begin
            if (v[(k+1)*data_width +: data_width] < v[k*data_width +: data_width])
                bad = 1'b1;
        end
        return bad;
    endfunction

    // Returns 1 when some output element occurs a different number of times
    // in the output than in the input.
    function automatic logic perm_bad(input logic [VW-1:0] src, input logic [VW-1:0] res);
        logic                  bad;
        logic [data_width-1:0] e;
        int                    cnt_src;
        int                    cnt_res;
        bad = 1'b0;
        for (int j = 0; j < num_elem; j++) begin
            e       = res[j*data_width +: data_width];
            cnt_src = 0;
            cnt_res = 0;
            for (int i = 0; i < num_elem; i++) begin
                if (src[i*data_width +: data_width] == e) cnt_src++;
                if (res[i*data_width +: data_width] == e) cnt_res++;
            end
            if (cnt_src != cnt_res) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---- delay line: aligns inps/in_valid with the sorter output ----
    logic          del_vld;
    logic [VW-1:0] del_inps;

    generate
        if (latency == 0) begin : g_nodly
            assign del_vld  = in_valid;
            assign del_inps = inps;
        end else begin : g_dly
            logic [latency-1:0] vld_q;
            logic [VW-1:0]      dat_q [latency];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < latency; i++) dat_q[i] <= '0;
                end else if (clear) begin
                    vld_q <= '0;
                    for (int i = 0; i < latency; i++) dat_q[i] <= '0;
                end else begin
                    vld_q[0] <= in_valid;
                    dat_q[0] <= inps;
                    for (int i = 1; i < latency; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign del_vld  = vld_q[latency-1];
            assign del_inps = dat_q[latency-1];
        end
    endgenerate

    // HALT blocks new checks; anything still in the delay line is dropped.
    logic check_en;
    assign check_en = del_vld && (state != HALT);

    // ---- stage p0: registered check result ----
    logic          vld_p0;
    logic          ord_p0;
    logic          prm_p0;
    logic [VW-1:0] inps_p0;
    logic [VW-1:0] outp_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            ord_p0  <= 1'b0;
            prm_p0  <= 1'b0;
            inps_p0 <= '0;
            outp_p0 <= '0;
        end else if (clear) begin
            vld_p0  <= 1'b0;
            ord_p0  <= 1'b0;
            prm_p0  <= 1'b0;
            inps_p0 <= '0;
            outp_p0 <= '0;
        end else begin
            vld_p0  <= check_en;
            ord_p0  <= order_bad(outp);
            prm_p0  <= perm_bad(del_inps, outp);
            inps_p0 <= del_inps;
            outp_p0 <= outp;
        end
    end

    logic fail_p0;
    logic upd_p0;
    assign fail_p0 = ord_p0 | prm_p0;
    // A result still in p0 when HALT is reached belongs to a discarded vector.
    assign upd_p0  = vld_p0 && (state != HALT);

    // ---- stage p1: counters and first-failure capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checks_done    <= '0;
            err_count      <= '0;
            err_flag       <= 1'b0;
            err_kind       <= '0;
            first_err_inps <= '0;
            first_err_outp <= '0;
        end else if (clear) begin
            checks_done    <= '0;
            err_count      <= '0;
            err_flag       <= 1'b0;
            err_kind       <= '0;
            first_err_inps <= '0;
            first_err_outp <= '0;
        end else if (upd_p0) begin
            checks_done <= sat_inc(checks_done);
            if (fail_p0) begin
                err_count <= sat_inc(err_count);
                if (!err_flag) begin
                    err_flag       <= 1'b1;
                    err_kind       <= {prm_p0, ord_p0};
                    first_err_inps <= inps_p0;
                    first_err_outp <= outp_p0;
                end
            end
        end
    end

    // ---- FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     state <= IDLE;
        else if (clear) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = RUN;
            RUN:  if ((stop_on_err != 0) && upd_p0 && fail_p0) state_nx = HALT;
            HALT: state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_sort_result_checker.sv
module tb_sort_result_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] inps = '0;
    logic [5:0] outp = '0;

    always #5 clk = ~clk;

    // default-parameter instance
    logic [15:0] a_cd, a_ec;
    logic        a_ef, a_busy;
    logic [1:0]  a_ek;
    logic [5:0]  a_fi, a_fo;

    sort_result_checker u_def (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .inps(inps), .outp(outp),
        .checks_done(a_cd), .err_count(a_ec), .err_flag(a_ef), .err_kind(a_ek),
        .first_err_inps(a_fi), .first_err_outp(a_fo), .busy(a_busy)
    );

    // latency = 2 instance
    logic [15:0] b_cd, b_ec;
    logic        b_ef, b_busy;
    logic [1:0]  b_ek;
    logic [5:0]  b_fi, b_fo;

    sort_result_checker #(.latency(2)) u_lat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .inps(inps), .outp(outp),
        .checks_done(b_cd), .err_count(b_ec), .err_flag(b_ef), .err_kind(b_ek),
        .first_err_inps(b_fi), .first_err_outp(b_fo), .busy(b_busy)
    );

    // stop_on_err = 1 instance
    logic [15:0] c_cd, c_ec;
    logic        c_ef, c_busy;
    logic [1:0]  c_ek;
    logic [5:0]  c_fi, c_fo;

    sort_result_checker #(.stop_on_err(1)) u_stop (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .inps(inps), .outp(outp),
        .checks_done(c_cd), .err_count(c_ec), .err_flag(c_ef), .err_kind(c_ek),
        .first_err_inps(c_fi), .first_err_outp(c_fo), .busy(c_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    function automatic logic [5:0] sort2(input logic [5:0] v);
        logic [2:0] e0, e1;
        e0 = v[2:0];
        e1 = v[5:3];
        return (e1 < e0) ? {e0, e1} : {e1, e0};
    endfunction

    typedef struct {
        logic [5:0] inps;
        logic [5:0] outp;
        logic       fail;
        logic [1:0] kind;
    } vec_t;

    vec_t       tbl [8];
    logic [5:0] lv  [5];

    initial begin
        tbl[0] = '{6'b101_010, 6'b101_010, 1'b0, 2'b00};
        tbl[1] = '{6'b101_010, 6'b010_101, 1'b1, 2'b01};
        tbl[2] = '{6'b011_001, 6'b011_011, 1'b1, 2'b10};
        tbl[3] = '{6'b100_100, 6'b100_100, 1'b0, 2'b00};
        tbl[4] = '{6'b011_001, 6'b001_011, 1'b1, 2'b01};
        tbl[5] = '{6'b001_010, 6'b000_111, 1'b1, 2'b11};
        tbl[6] = '{6'b111_000, 6'b111_000, 1'b0, 2'b00};
        tbl[7] = '{6'b000_000, 6'b000_000, 1'b0, 2'b00};

        lv[0] = 6'b010_110;
        lv[1] = 6'b001_011;
        lv[2] = 6'b111_000;
        lv[3] = 6'b000_101;
        lv[4] = 6'b100_100;

        // reset state
        #12;
        chk("rst_cd", a_cd, 0);
        chk("rst_ec", a_ec, 0);
        chk("rst_ef", a_ef, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_lat_busy", b_busy, 0);
        chk("rst_stop_cd", c_cd, 0);
        rst_n = 1'b1;
        tick();

        // single-vector table on the default instance
        for (int i = 0; i < 8; i++) begin
            do_clear();
            inps = tbl[i].inps;
            outp = tbl[i].outp;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_cd_early", i), a_cd, 0);
            chk($sformatf("tbl%0d_busy", i), a_busy, 1);
            tick();
            chk($sformatf("tbl%0d_cd", i), a_cd, 1);
            chk($sformatf("tbl%0d_ec", i), a_ec, {31'd0, tbl[i].fail});
            chk($sformatf("tbl%0d_ef", i), a_ef, {31'd0, tbl[i].fail});
            chk($sformatf("tbl%0d_ek", i), a_ek, {30'd0, tbl[i].kind});
            chk($sformatf("tbl%0d_fi", i), a_fi, tbl[i].fail ? {26'd0, tbl[i].inps} : 32'd0);
            chk($sformatf("tbl%0d_fo", i), a_fo, tbl[i].fail ? {26'd0, tbl[i].outp} : 32'd0);
        end

        // latency = 2: correct sorter delayed by two cycles
        do_clear();
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 5);
            inps = (c < 5) ? lv[c] : 6'd0;
            outp = (c >= 2 && c < 7) ? sort2(lv[c-2]) : 6'd0;
            tick();
            chk($sformatf("lat_cd_c%0d", c), b_cd, (c < 3) ? 0 : c - 2);
        end
        in_valid = 1'b0;
        chk("lat_ec", b_ec, 0);
        chk("lat_ef", b_ef, 0);
        chk("lat_busy", b_busy, 1);

        // stop_on_err: 2nd of 3 vectors fails
        do_clear();
        in_valid = 1'b1;
        inps = 6'b101_010; outp = 6'b101_010; tick();
        inps = 6'b101_010; outp = 6'b010_101; tick();
        inps = 6'b100_100; outp = 6'b100_100; tick();
        chk("stop_busy_fall", c_busy, 0);
        inps = 6'b011_001; outp = 6'b011_011; tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("stop_cd", c_cd, 2);
        chk("stop_ec", c_ec, 1);
        chk("stop_ef", c_ef, 1);
        chk("stop_ek", c_ek, 2'b01);
        chk("stop_fi", c_fi, 6'b101_010);
        chk("stop_fo", c_fo, 6'b010_101);
        chk("stop_busy", c_busy, 0);
        do_clear();
        chk("clr_cd", c_cd, 0);
        chk("clr_ec", c_ec, 0);
        chk("clr_ef", c_ef, 0);
        chk("clr_ek", c_ek, 0);
        chk("clr_fi", c_fi, 0);
        chk("clr_fo", c_fo, 0);
        chk("clr_busy", c_busy, 0);
        in_valid = 1'b1;
        inps = 6'b101_010; outp = 6'b101_010; tick();
        in_valid = 1'b0;
        tick();
        chk("clr_rerun_busy", c_busy, 1);
        chk("clr_rerun_cd", c_cd, 1);

        // saturation on the default instance
        do_clear();
        in_valid = 1'b1;
        inps = 6'b101_010; outp = 6'b010_101; tick();
        inps = 6'b011_001; outp = 6'b011_011;
        for (int i = 0; i < 65533; i++) @(posedge clk);
        #1;
        in_valid = 1'b0;
        tick();
        chk("sat_ec_fffe", a_ec, 16'hFFFE);
        chk("sat_cd_fffe", a_cd, 16'hFFFE);
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        tick();
        chk("sat_ec", a_ec, 16'hFFFF);
        chk("sat_cd", a_cd, 16'hFFFF);
        chk("sat_ek", a_ek, 2'b01);
        chk("sat_fi", a_fi, 6'b101_010);
        chk("sat_fo", a_fo, 6'b010_101);

        // asynchronous reset mid-stream
        in_valid = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cd", a_cd, 0);
        chk("arst_ec", a_ec, 0);
        chk("arst_ef", a_ef, 0);
        chk("arst_ek", a_ek, 0);
        chk("arst_fi", a_fi, 0);
        chk("arst_fo", a_fo, 0);
        chk("arst_busy", a_busy, 0);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
